// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 sizes, FSM states,
// byte-enable patterns and the store lane-replication helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  // Size decode uses funct3[1:0] only; any encoding with bit 1 set is a word.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   store_be = BE_B << a;
      2'b01:   store_be = BE_H << {a[1], 1'b0};
      default: store_be = BE_W;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_wdata = {4{d[7:0]}};
      2'b01:   store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    if (f3[1])
      is_misaligned = (a != 2'b00);
    else if (f3[0])
      is_misaligned = a[0];
    else
      is_misaligned = 1'b0;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load return path: picks the byte/half lane from the bus word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_B:    data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_H:    data_o = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_HU:   data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one bus transaction per request, stalling the pipe
// until completion. Optional LSU_MISALIGN_TRAP_EN adds misalign_o and skips the bus.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  input  logic                       mem_read_i,
  input  logic                       mem_write_i,
  input  logic [2:0]                 funct3_i,
  input  logic [DATA_ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  output logic                       dmem_req_o,
  output logic                       dmem_we_o,
  output logic [3:0]                 dmem_be_o,
  output logic [DATA_ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0]      dmem_wdata_o,
  input  logic                       dmem_ready_i,
  input  logic [DATA_WIDTH-1:0]      dmem_rdata_i,
  output logic                       stall_o,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                       misalign_o,
`endif
  output logic [DATA_WIDTH-1:0]      load_data_o,
  output logic                       load_valid_o
);

  lsu_state_e                 state_q, state_d;
  logic                       req_q;
  logic                       we_q;
  logic [3:0]                 be_q;
  logic [DATA_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic [2:0]                 f3_q;
  logic [1:0]                 lo_q;
  logic [DATA_WIDTH-1:0]      ld_data_q;
  logic                       ld_vld_q;
  logic [DATA_WIDTH-1:0]      ld_aligned;
  logic                       req_any;
  logic                       accept;
  logic                       mis_req;

  assign req_any = mem_read_i | mem_write_i;
  assign accept  = (state_q == S_IDLE) && req_any;

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  assign mis_req    = is_misaligned(funct3_i, addr_i[1:0]);
  assign misalign_o = mis_q;

  // Only high during the DONE cycle that follows a trapped request.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) mis_q <= 1'b0;
    else         mis_q <= accept && mis_req;
  end
`else
  assign mis_req = 1'b0;
`endif

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_any) state_d = mis_req ? S_DONE : S_REQ;
      S_REQ:   if (dmem_ready_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stall rises in the accept cycle itself so EX/MEM holds the request.
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      S_IDLE:  stall_o = req_any;
      S_REQ:   stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      lo_q      <= '0;
      ld_data_q <= '0;
      ld_vld_q  <= 1'b0;
    end else begin
      req_q    <= (state_d == S_REQ);
      ld_vld_q <= 1'b0;
      if (accept) begin
        // Read+write together is a store.
        we_q    <= mem_write_i;
        be_q    <= mem_write_i ? store_be(funct3_i, addr_i[1:0]) : BE_W;
        addr_q  <= {addr_i[DATA_ADDR_WIDTH-1:2], 2'b00};
        wdata_q <= mem_write_i ? store_wdata(funct3_i, wdata_i) : '0;
        f3_q    <= funct3_i;
        lo_q    <= addr_i[1:0];
      end
      if ((state_q == S_REQ) && dmem_ready_i && !we_q) begin
        ld_data_q <= ld_aligned;
        ld_vld_q  <= 1'b1;
      end
    end
  end

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata_i   (dmem_rdata_i),
    .addr_lo_i (lo_q),
    .funct3_i  (f3_q),
    .data_o    (ld_aligned)
  );

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_be_o    = be_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign load_data_o  = ld_data_q;
  assign load_valid_o = ld_vld_q;

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data and address width; only 32 is supported.
REQ-002 SHALL have parameter DATA_ADDR_WIDTH, default 32, byte address width.
REQ-003 cpu_clk  in  1  sole clock, rising edge.
REQ-004 cpu_rst  in  1  reset, synchronous, active-high.
REQ-005 mem_read_i  in  1  load request from EX/MEM register.
REQ-006 mem_write_i  in  1  store request from EX/MEM register.
REQ-007 funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr_i  in  DATA_ADDR_WIDTH  byte address (ALU result).
REQ-009 wdata_i  in  DATA_WIDTH  store data, right-aligned.
REQ-010 dmem_req_o  out  1  bus request, registered.
REQ-011 dmem_we_o, dmem_be_o[3:0], dmem_addr_o, dmem_wdata_o  out  bus write flag, byte enables, word-aligned address, lane-aligned data.
REQ-012 dmem_ready_i  in  1  bus completion; dmem_rdata_i  in  DATA_WIDTH  read word, valid with ready.
REQ-013 stall_o  out  1  freezes IF..EX/MEM while high; load_data_o  out  DATA_WIDTH; load_valid_o  out  1.

Function
REQ-014 SHALL implement FSM IDLE, REQ, DONE.
REQ-015 IDLE with no request: stall_o=0, dmem_req_o=0, remain IDLE.
REQ-016 IDLE with a request: stall_o=1 combinationally in the same cycle; next state REQ; latch addr, funct3, wdata, and write flag.
REQ-017 REQ: dmem_req_o=1, stall_o=1; bus outputs held stable until dmem_ready_i=1; on ready, go to DONE.
REQ-018 DONE: stall_o=0 and dmem_req_o=0 for exactly one cycle; load_valid_o=1 for loads; unconditional return to IDLE, with no re-acceptance of the same request.
REQ-019 Minimum stall is 2 cycles (ready in the first REQ cycle); each extra cycle without ready adds 1.
REQ-020 Store byte enables:
- SB: be = 0001 << addr[1:0], byte replicated on all lanes.
- SH: be = 0011 << (2*addr[1]), half replicated.
- SW: be = 1111.
REQ-021 Load extract: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through; capture into load_data_o on the ready edge; hold until the next load completes.
REQ-022 Requests with mem_read_i and mem_write_i both high SHALL be treated as stores.
REQ-023 dmem_addr_o = {addr[31:2], 2'b00}; dmem_we_o is 0 for loads and dmem_be_o is 1111 for loads.

Reset
REQ-024 On cpu_rst: state IDLE; dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o, load_data_o, and load_valid_o SHALL all be 0.
REQ-025 Reset mid-transaction SHALL drop dmem_req_o the next cycle; the late dmem_ready_i is ignored.

Configuration
REQ-026 Macro LSU_MISALIGN_TRAP_EN adds output misalign_o (1 bit).
- Defined: H with addr[0]=1, or W with addr[1:0]!=0, issues no bus request; IDLE goes directly to DONE; misalign_o=1 in DONE only; load_data_o is unchanged.
- Undefined: the port is absent; misaligned H uses addr[1] only, misaligned W ignores addr[1:0].

Structure
REQ-027 Package lsu_pkg SHALL hold funct3 encodings, the FSM state enum, and the BE constants.
REQ-028 Combinational sub-module lsu_load_align (lane select, sign/zero-extend) SHALL be instantiated once.

Verification
REQ-029 SW addr 0x100, data 0xDEADBEEF, ready in the 1st REQ cycle -> be=1111, addr=0x100, stall exactly 2 cycles, one DONE cycle.
REQ-030 SB addr 0x103, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5.
REQ-031 LB addr 0x102, rdata 0x0080FF00 -> load_data_o=0xFFFFFF80; LBU -> 0x00000080; LH addr 0x102 -> 0x00000080.
REQ-032 LW with ready delayed 3 cycles -> stall_o high 5 cycles, dmem_req_o stable throughout.
REQ-033 cpu_rst during REQ, then ready -> IDLE, no load_valid_o, outputs zero.
REQ-034 With LSU_MISALIGN_TRAP_EN, LW addr 0x101 -> no dmem_req_o, misalign_o=1 in cycle 2, stall_o 1 cycle.
